// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan driver.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Counter width helper; never returns less than 1 so DIGITS=1 still gets a legal vector.
  function automatic int clog2(input int value);
    int width;
    for (width = 1; (1 << width) < value; width++) begin
    end
    return width;
  endfunction

endpackage

// File: rtl/seven_seg_hex.sv
// Hex nibble to 7-segment decoder; segments are {g,f,e,d,c,b,a}, active-high.
module seven_seg_hex (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'b0000000;
    case (nibble)
      4'h0: segments = 7'b0111111;
      4'h1: segments = 7'b0000110;
      4'h2: segments = 7'b1011011;
      4'h3: segments = 7'b1001111;
      4'h4: segments = 7'b1100110;
      4'h5: segments = 7'b1101101;
      4'h6: segments = 7'b1111101;
      4'h7: segments = 7'b0000111;
      4'h8: segments = 7'b1111111;
      4'h9: segments = 7'b1101111;
      4'hA: segments = 7'b1110111;
      4'hB: segments = 7'b1111100;
      4'hC: segments = 7'b0111001;
      4'hD: segments = 7'b1011110;
      4'hE: segments = 7'b1111001;
      4'hF: segments = 7'b1110001;
      default: segments = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit 7-segment scan driver with double-buffered value and per-slot blanking.
// Define SEVEN_SEG_LZ_BLANK_EN to suppress leading zeros on digits above digit 0.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int CLK_DIV   = 1200,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  localparam int IDX_W = clog2(DIGITS);
  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [4*DIGITS-1:0]  disp_reg;
  logic [4*DIGITS-1:0]  pending_reg;
  logic                 pending_valid_reg;
  logic [6:0]           seg_reg;
  logic [DIGITS-1:0]    dig_reg;
  logic                 frame_start_reg;

  logic                 slot_end;
  logic                 frame_end;
  logic                 transfer;
  logic [DIGITS-1:0]    idx_onehot;
  logic [3:0]           nibble;
  logic [6:0]           seg_dec;
  logic                 lz_blank;

  assign slot_end    = (cnt_reg == CNT_LAST);
  assign frame_end   = slot_end && (idx_reg == IDX_LAST);
  assign value_ready = !pending_valid_reg && !rst;
  assign transfer    = value_valid && value_ready;

  // Scan sequencing: counter, digit index and BLANK/SHOW state
  always_comb begin
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    state_next = state_reg;
    if (slot_end) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end
    case (state_reg)
      BLANK:   if (cnt_reg == BLANK_LAST) state_next = SHOW;
      SHOW:    if (slot_end) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Double buffer: the displayed value only changes on the edge that starts a new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg          <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
    end else if (frame_end && pending_valid_reg) begin
      disp_reg          <= pending_reg;
      pending_valid_reg <= 1'b0;
    end else if (transfer) begin
      pending_reg       <= value_in;
      pending_valid_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
      assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    nibble = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_onehot[k]) nibble = disp_reg[4*k +: 4];
    end
  end

  seven_seg_hex u_hex (
    .nibble   (nibble),
    .segments (seg_dec)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // zero_from[k]: nibble k and every nibble above it are zero
  logic [DIGITS:0]   zero_from;
  logic [DIGITS-1:0] lz_mask;

  assign zero_from[DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign zero_from[gi] = (disp_reg[4*gi +: 4] == 4'h0) && zero_from[gi+1];
    end
  endgenerate

  assign lz_mask  = zero_from[DIGITS-1:0] & ~DIGITS'(1);
  assign lz_blank = |(idx_onehot & lz_mask);
`else
  assign lz_blank = 1'b0;
`endif

  // Registered pins: one cycle behind state/idx
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg         <= SEG_OFF;
      dig_reg         <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      seg_reg         <= (state_reg == SHOW && !lz_blank) ? seg_dec : SEG_OFF;
      dig_reg         <= (state_reg == SHOW) ? idx_onehot : '0;
      frame_start_reg <= (state_reg == BLANK) && (idx_reg == '0) && (cnt_reg == '0);
    end
  end

  assign seg_out     = seg_reg;
  assign dig_sel     = dig_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DIGITS=2, CLK_DIV=8, BLANK_CYC=2.
module tb_seven_seg_scan;

  localparam int DIGITS    = 2;
  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [6:0] ZERO_HI = 7'b0000000;
`else
  localparam logic [6:0] ZERO_HI = 7'b0111111;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value_in = 8'h00;
  logic       value_valid = 1'b0;
  logic       value_ready;
  logic [6:0] seg_out;
  logic [1:0] dig_sel;
  logic       frame_start;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string      name;
    logic [7:0] value;
    logic [6:0] d0;
    logic [6:0] d1;
  } vec_t;

  vec_t vecs [6];

  seven_seg_scan #(
    .DIGITS    (DIGITS),
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg_out     (seg_out),
    .dig_sel     (dig_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (value_ready !== 1'b1 && n < 64) begin
      tick;
      n++;
    end
    chk({name, " ready"}, {7'd0, value_ready}, 8'd1);
  endtask

  task automatic send(input logic [7:0] v);
    value_in    = v;
    value_valid = 1'b1;
    wait_ready("send");
    tick;
    value_valid = 1'b0;
    chk("ready low after accept", {7'd0, value_ready}, 8'd0);
    $display("sent value %02h", v);
  endtask

  // Called on the pin cycle that should carry frame_start; checks all 16 cycles of the frame.
  task automatic check_frame(input string name, input logic [6:0] d0, input logic [6:0] d1);
    logic [6:0] es;
    logic [1:0] ed;
    int         slot;
    for (int j = 0; j < 16; j++) begin
      slot = j % 8;
      es   = 7'b0000000;
      ed   = 2'b00;
      if (slot >= 2) begin
        es = (j < 8) ? d0 : d1;
        ed = (j < 8) ? 2'b01 : 2'b10;
      end
      chk($sformatf("%s frame_start c%0d", name, j), {7'd0, frame_start}, {7'd0, j == 0});
      chk($sformatf("%s seg_out c%0d", name, j), {1'b0, seg_out}, {1'b0, es});
      chk($sformatf("%s dig_sel c%0d", name, j), {6'd0, dig_sel}, {6'd0, ed});
      tick;
    end
    $display("frame %s: d0=%07b d1=%07b checked", name, d0, d1);
  endtask

  task automatic show(input vec_t v);
    send(v.value);
    wait_ready("boundary");
    tick;
    check_frame(v.name, v.d0, v.d1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{"0x3A", 8'h3A, 7'b1110111, 7'b1001111};
    vecs[1] = '{"0xF0", 8'hF0, 7'b0111111, 7'b1110001};
    vecs[2] = '{"0x05", 8'h05, 7'b1101101, ZERO_HI};
    vecs[3] = '{"0x8C", 8'h8C, 7'b0111001, 7'b1111111};
    vecs[4] = '{"0x0B", 8'h0B, 7'b1111100, ZERO_HI};
    vecs[5] = '{"0xD6", 8'hD6, 7'b1111101, 7'b1011110};

    // Reset state
    repeat (3) tick;
    chk("reset seg_out", {1'b0, seg_out}, 8'h00);
    chk("reset dig_sel", {6'd0, dig_sel}, 8'h00);
    chk("reset frame_start", {7'd0, frame_start}, 8'h00);
    chk("reset ready", {7'd0, value_ready}, 8'h00);
    rst = 1'b0;
    #1;
    chk("ready after reset", {7'd0, value_ready}, 8'h01);
    tick;
    check_frame("post-reset 0x00", 7'b0111111, ZERO_HI);

    for (int i = 0; i < 6; i++) show(vecs[i]);

    // Back-pressure: 0x11 accepted, 0x22 held until the boundary
    value_in    = 8'h11;
    value_valid = 1'b1;
    tick;
    chk("bp ready low after 0x11", {7'd0, value_ready}, 8'h00);
    value_in = 8'h22;
    n = 0;
    while (value_ready !== 1'b1 && n < 64) begin
      tick;
      n++;
    end
    chk("bp cycles ready low", 8'(n), 8'd14);
    chk("bp frame_start before boundary", {7'd0, frame_start}, 8'h00);
    tick;
    value_valid = 1'b0;
    chk("bp 0x22 accepted", {7'd0, value_ready}, 8'h00);
    $display("sent value 22 under back-pressure");
    check_frame("bp 0x11", 7'b0000110, 7'b0000110);
    check_frame("bp 0x22", 7'b1011011, 7'b1011011);

    // Reset during SHOW of digit 1 with a value pending
    repeat (12) tick;
    chk("mid seg_out before reset", {1'b0, seg_out}, {1'b0, 7'b1011011});
    chk("mid dig_sel before reset", {6'd0, dig_sel}, 8'h02);
    value_in    = 8'h77;
    value_valid = 1'b1;
    tick;
    value_valid = 1'b0;
    chk("mid pending held", {7'd0, value_ready}, 8'h00);
    rst = 1'b1;
    tick;
    chk("mid reset seg_out", {1'b0, seg_out}, 8'h00);
    chk("mid reset dig_sel", {6'd0, dig_sel}, 8'h00);
    chk("mid reset ready", {7'd0, value_ready}, 8'h00);
    rst = 1'b0;
    #1;
    chk("mid ready after reset", {7'd0, value_ready}, 8'h01);
    tick;
    check_frame("after mid reset 0x00", 7'b0111111, ZERO_HI);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Multiplexed scan driver for an N-digit common-cathode 7-segment display.
- Sits upstream of the nibble-to-segment decoder `seven_seg_hex` and instantiates it.
- Accepts a hex value over a valid/ready handshake and double-buffers it.
- Time-slices digits with a blanking interval between slots (anti-ghosting) and drives registered segment and digit-select outputs.

Parameters:
- DIGITS, 2, number of digits scanned (>=1).
- CLK_DIV, 1200, clock cycles per digit slot (>= BLANK_CYC+2).
- BLANK_CYC, 16, cycles at the start of each slot during which all outputs are dark (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- value_in  in  4*DIGITS  hex value; nibble k is digit k, digit 0 = least significant.
- value_valid  in  1  value_in is valid this cycle.
- value_ready  out  1  block can accept value_in.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high (1 = lit).
- dig_sel  out  DIGITS  one-hot digit enable, active-high; all-zero = dark.
- frame_start  out  1  one-cycle pulse on entering BLANK for digit 0.

Behaviour:
- Reset (rst=1 at clk edge) clears the following:
  - seg_out=0, dig_sel=0, frame_start=0.
  - state=BLANK, idx=0, slot counter=0.
  - disp_reg=0, pending_valid=0.
  - value_ready is driven as (!pending_valid && !rst), so it is 0 while rst is high.
- Slot counter cnt runs 0..CLK_DIV-1 and wraps to 0. The wrap is the slot end and advances idx, which wraps DIGITS-1 -> 0.
- FSM states and transitions:
  - BLANK while cnt < BLANK_CYC, otherwise SHOW.
  - BLANK -> SHOW when cnt = BLANK_CYC-1.
  - SHOW -> BLANK at cnt = CLK_DIV-1, with idx advancing on the same edge.
- Handshake:
  - A transfer occurs when value_valid && value_ready.
  - On transfer: pending <= value_in, pending_valid <= 1.
  - value_ready stays low while pending_valid=1.
- Frame boundary (transition into BLANK with idx -> 0, and the first cycle after reset):
  - If pending_valid, then disp_reg <= pending and pending_valid <= 0.
  - value_ready rises the following cycle.
  - An update never occurs mid-frame, so there is no tearing.
- Transfer and boundary in the same cycle are impossible, because ready is low whenever pending_valid is high.
- Decode path:
  - nibble = disp_reg[4*idx +: 4] feeds seven_seg_hex combinationally.
  - seg_out and dig_sel are registered, giving a 1-cycle latency from state/idx to the pins.
- Output values:
  - In BLANK: seg_out=0, dig_sel=0.
  - In SHOW: seg_out = decoded nibble, dig_sel = 1<<idx.
- frame_start asserts for exactly one cycle, aligned with the first registered BLANK output of digit 0; its period is DIGITS*CLK_DIV cycles.
- DIGITS=1: idx stays 0 and every slot is a frame boundary.
- Reset mid-operation discards pending data and displayed data.

Optional Feature:
- Macro SEVEN_SEG_LZ_BLANK_EN enables leading-zero suppression.
  - A digit k>0 whose nibble and all higher nibbles of disp_reg are 0 shows seg_out=0 in SHOW; dig_sel timing is unchanged.
  - Digit 0 is always shown.
- Without the macro, all digits show their decoded nibble, including zeros (7'b0111111).

Decomposition:
- Package seven_seg_pkg holds:
  - state typedef enum {BLANK, SHOW};
  - constant SEG_OFF = 7'b0000000;
  - function clog2 for the idx/cnt widths.
- One sub-module: an instance of the existing seven_seg_hex, with nibble in and segments out.
- The scan FSM, counters and buffers live in seven_seg_scan.

Test Plan (DIGITS=2, CLK_DIV=8, BLANK_CYC=2):
- Reset, then 0x3A with valid=1 for one cycle -> ready drops. After the next frame boundary:
  - digit 0 shows seg_out=7'b1110111 with dig_sel=01;
  - digit 1 shows 7'b1001111 with dig_sel=10.
- Slot timing -> per 8-cycle slot: 2 cycles seg_out=0/dig_sel=00, then 6 cycles lit; frame_start pulses every 16 cycles.
- Back-pressure:
  - 0x11 is accepted; 0x22 is held valid.
  - ready stays low until the boundary and 0x22 is accepted 1 cycle after it.
  - The display shows 0x11 for one full frame, then 0x22.
- Reset asserted mid-SHOW of digit 1 -> next cycle seg_out=0, dig_sel=0, ready=0. After deassert, 0x00 is displayed and the previously pending value is lost.
- Value 0x05:
  - with SEVEN_SEG_LZ_BLANK_EN -> digit 1 SHOW has seg_out=0 and dig_sel=10;
  - without it -> digit 1 seg_out=7'b0111111.
  - Digit 0 seg_out=7'b1101101 in both cases.
- Value 0xF0 -> digit 0 = 7'b0111111, digit 1 = 7'b1110001; idx wraps 1 -> 0 coincident with frame_start.
